turn_scheduler: RTL and testbench
=================================

Name: turn_scheduler

Overview:
Sequences the four per-player board-position counters in the chicken board game. It owns turn order and issues per-player advance enables (p_da[k]) for exactly the number of tiles won, one tile per clock. It also keeps a mirror of each player's position and distance travelled so it can detect a winner. It sits between the button/card-match logic and the cnt_player* instances, which share its clock.

Parameters:
TILES, 24, board length; positions wrap TILES-1 -> 0
STEP_W, 2, width of the steps request (1..3 tiles per hit)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
N  in  2  player-count code: 0->2 players, 1->3, 2->4, 3->4; sampled only at reset release / new_game
new_game  in  1  synchronous restart pulse
go  in  1  one-cycle pulse: current player has revealed a card
hit  in  1  valid with go: card matched the tile ahead
steps  in  STEP_W  valid with go: tiles to advance on a hit; 0 treated as 1
p_da  out  4  per-player advance enable; bit k high for one clk per tile moved
turn  out  2  index of the active player
busy  out  1  high while in MOVE
pos0..pos3  out  5 each  mirrored positions, 0..TILES-1
winner_valid  out  1  high in DONE
winner  out  2  winning player index, valid with winner_valid

Behaviour:
- Reset (async) and new_game (sync) both force the following. p_da=0, turn=0, busy=0, winner_valid=0, winner=0, state=WAIT.
- On reset/new_game, players = decoded N. pos[k] = k*(TILES/players) for active k, 0 for inactive k. That gives 0/12 for 2 players, 0/8/16 for 3, 0/6/12/18 for 4. dist[k]=0.
- FSM states: WAIT, MOVE, DONE.
- WAIT, go=1, hit=1: latch rem = max(steps,1) and enter MOVE on the next cycle.
- WAIT, go=1, hit=0: turn advances to (turn+1) mod players in the same cycle; state stays WAIT.
- WAIT, go=0: hold all state.
- MOVE, each cycle:
  - p_da = one-hot(turn).
  - pos[turn] = (pos[turn]==TILES-1) ? 0 : pos[turn]+1.
  - dist[turn] += 1, saturating at 31.
  - rem -= 1.
  - After the cycle in which rem reaches 0, p_da drops and the state returns to WAIT. turn is unchanged, so a successful player keeps the turn.
- Latency: go sampled at edge t. p_da is high on cycles t+1 .. t+rem, so exactly rem rising edges see p_da[turn]=1.
- Win check: if dist[turn] reaches TILES during MOVE, the move stops on that cycle even if rem>0. State goes to DONE, winner=turn, winner_valid=1, p_da=0.
- DONE: all outputs hold; go is ignored. Only new_game or rst exits.
- go during MOVE or DONE is ignored; there is no queuing.
- Turn rotation skips inactive players: with 3 players, 2 -> 0.
- N changes outside reset/new_game have no effect.
- Reset asserted mid-MOVE: p_da goes to 0 immediately (async) and the partial move is lost.
- Only one p_da bit is ever high; p_da is registered and glitch-free.

Decomposition:
- Shared package game_pkg holds:
  - constants TILES=24 and MAX_PLAYERS=4;
  - the state enum {WAIT, MOVE, DONE};
  - a function players_from_N(N);
  - a function start_pos(k, players).
- One sub-module: turn_rotator. It is combinational and computes next active index from turn and players.
- FSM, position mirror and distance counters stay in the top module.

Test Plan:
1. N=2, rst, go/hit=1/steps=3 -> p_da=0001 for exactly 3 cycles. pos0 0->3, busy high 3 cycles, turn stays 0.
2. N=1 (3 players), go with hit=0 three times -> turn 0->1->2->0. p_da never asserted; pos = 0/8/16 unchanged.
3. N=0, pos1=12 -> 4 hits of steps=3 on player 1 -> pos1 wraps 23->0 and ends at 0. dist1=12.
4. N=0, player 0 makes hits until dist0=23, then go/hit=1/steps=3 -> exactly 1 p_da pulse. DONE, winner=0, winner_valid=1; later go ignored.
5. go asserted during MOVE (hit=0) -> ignored. Move completes its full count and turn is unchanged.
6. rst asserted on the 2nd cycle of a 3-step MOVE -> p_da=0 immediately and all outputs at reset values. pos re-derived from N.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, state encoding and setup helpers for the chicken board game.
package game_pkg;

    localparam int TILES       = 24;
    localparam int MAX_PLAYERS = 4;
    localparam int POS_W       = 5;
    localparam int PLAYER_W    = 3;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [PLAYER_W-1:0] players_from_N(input logic [1:0] n);
        case (n)
            2'd0:    return 3'd2;
            2'd1:    return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    // Active players are spread evenly around the board; inactive ones park at 0.
    function automatic logic [POS_W-1:0] start_pos(input logic [1:0] k,
                                                   input logic [PLAYER_W-1:0] players);
        logic [POS_W-1:0] spacing;
        case (players)
            3'd2:    spacing = POS_W'(TILES / 2);
            3'd3:    spacing = POS_W'(TILES / 3);
            default: spacing = POS_W'(TILES / 4);
        endcase
        if ({1'b0, k} >= players) begin
            return '0;
        end
        return {3'b000, k} * spacing;
    endfunction

endpackage

// File: rtl/turn_rotator.sv
// Picks the next player in turn order, wrapping past the last active player.
module turn_rotator
    import game_pkg::*;
(
    input  logic [1:0]          turn_i,
    input  logic [PLAYER_W-1:0] players_i,
    output logic [1:0]          next_turn_o
);

    always_comb begin
        if (({1'b0, turn_i} + 3'd1) >= players_i) begin
            next_turn_o = 2'd0;
        end else begin
            next_turn_o = turn_i + 2'd1;
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: owns turn order, emits one advance pulse per tile won and
// mirrors every player's position and distance to spot the winner.
module turn_scheduler
    import game_pkg::*;
#(
    parameter int TILES  = game_pkg::TILES,
    parameter int STEP_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        n_i,
    input  logic              new_game_i,
    input  logic              go_i,
    input  logic              hit_i,
    input  logic [STEP_W-1:0] steps_i,
    output logic [3:0]        p_da_o,
    output logic [1:0]        turn_o,
    output logic              busy_o,
    output logic [POS_W-1:0]  pos0_o,
    output logic [POS_W-1:0]  pos1_o,
    output logic [POS_W-1:0]  pos2_o,
    output logic [POS_W-1:0]  pos3_o,
    output logic              winner_valid_o,
    output logic [1:0]        winner_o
);

    state_e              state_q, state_d;
    logic [PLAYER_W-1:0] players_q, eff_players;
    logic                load_pend_q;
    logic [POS_W-1:0]    pos_q  [MAX_PLAYERS];
    logic [POS_W-1:0]    pos_d  [MAX_PLAYERS];
    logic [POS_W-1:0]    eff_pos[MAX_PLAYERS];
    logic [POS_W-1:0]    dist_q [MAX_PLAYERS];
    logic [POS_W-1:0]    dist_d [MAX_PLAYERS];
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic [1:0]          turn_q, turn_d, winner_q, winner_d, next_turn;
    logic [3:0]          p_da_q, p_da_d;
    logic [POS_W-1:0]    dist_cur, dist_inc;
    logic                win_step, last_step;

    // Until the first edge after reset, N is taken live so outputs already show
    // the N-derived layout; that edge then latches it like a new_game would.
    always_comb begin
        eff_players = load_pend_q ? players_from_N(n_i) : players_q;
        for (int k = 0; k < MAX_PLAYERS; k++) begin
            eff_pos[k] = load_pend_q ? start_pos(2'(k), eff_players) : pos_q[k];
        end
    end

    turn_rotator u_turn_rotator (
        .turn_i      (turn_q),
        .players_i   (eff_players),
        .next_turn_o (next_turn)
    );

    always_comb begin
        dist_cur  = dist_q[turn_q];
        dist_inc  = (dist_cur == 5'd31) ? dist_cur : dist_cur + 5'd1;
        win_step  = (dist_inc >= POS_W'(TILES));
        last_step = (rem_q == STEP_W'(1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (new_game_i) begin
            state_d = WAIT;
        end else begin
            case (state_q)
                WAIT: if (go_i && hit_i) state_d = MOVE;
                MOVE: begin
                    if (win_step) begin
                        state_d = DONE;
                    end else if (last_step) begin
                        state_d = WAIT;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Decoded from next state so the registered enable lines up with the move.
    always_comb begin
        p_da_d = (state_d == MOVE) ? (4'b0001 << turn_d) : 4'b0000;
    end

    always_comb begin
        turn_d   = turn_q;
        rem_d    = rem_q;
        winner_d = winner_q;
        pos_d    = eff_pos;
        dist_d   = dist_q;
        if (new_game_i) begin
            turn_d   = 2'd0;
            rem_d    = '0;
            winner_d = 2'd0;
            for (int k = 0; k < MAX_PLAYERS; k++) begin
                pos_d[k]  = start_pos(2'(k), players_from_N(n_i));
                dist_d[k] = '0;
            end
        end else if (state_q == WAIT && go_i) begin
            if (hit_i) begin
                rem_d = (steps_i == '0) ? STEP_W'(1) : steps_i;
            end else begin
                turn_d = next_turn;
            end
        end else if (state_q == MOVE) begin
            pos_d[turn_q]  = (eff_pos[turn_q] == POS_W'(TILES - 1)) ? '0
                                                                     : eff_pos[turn_q] + 5'd1;
            dist_d[turn_q] = dist_inc;
            rem_d          = rem_q - STEP_W'(1);
            if (win_step) begin
                winner_d = turn_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            load_pend_q <= 1'b1;
            players_q   <= 3'd2;
            turn_q      <= 2'd0;
            rem_q       <= '0;
            winner_q    <= 2'd0;
            p_da_q      <= 4'b0000;
            for (int k = 0; k < MAX_PLAYERS; k++) begin
                pos_q[k]  <= '0;
                dist_q[k] <= '0;
            end
        end else begin
            load_pend_q <= 1'b0;
            players_q   <= new_game_i ? players_from_N(n_i) : eff_players;
            turn_q      <= turn_d;
            rem_q       <= rem_d;
            winner_q    <= winner_d;
            p_da_q      <= p_da_d;
            pos_q       <= pos_d;
            dist_q      <= dist_d;
        end
    end

    assign p_da_o         = p_da_q;
    assign turn_o         = turn_q;
    assign busy_o         = (state_q == MOVE);
    assign winner_valid_o = (state_q == DONE);
    assign winner_o       = winner_q;
    assign pos0_o         = eff_pos[0];
    assign pos1_o         = eff_pos[1];
    assign pos2_o         = eff_pos[2];
    assign pos3_o         = eff_pos[3];

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: vector table plus hand-written multi-cycle sequences.
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] n;
    logic       newGame, go, hit;
    logic [1:0] steps;
    logic [3:0] pDa;
    logic [1:0] turn, winner;
    logic       busy, winnerValid;
    logic [4:0] pos0, pos1, pos2, pos3;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic       ng;
        logic [1:0] n;
        logic       go;
        logic       hit;
        logic [1:0] steps;
        logic [3:0] pda;
        logic [1:0] turn;
        logic       busy;
        logic [4:0] p0, p1, p2, p3;
        logic       wv;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    turn_scheduler #(.TILES(24), .STEP_W(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .n_i            (n),
        .new_game_i     (newGame),
        .go_i           (go),
        .hit_i          (hit),
        .steps_i        (steps),
        .p_da_o         (pDa),
        .turn_o         (turn),
        .busy_o         (busy),
        .pos0_o         (pos0),
        .pos1_o         (pos1),
        .pos2_o         (pos2),
        .pos3_o         (pos3),
        .winner_valid_o (winnerValid),
        .winner_o       (winner)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        newGame = v.ng;
        n       = v.n;
        go      = v.go;
        hit     = v.hit;
        steps   = v.steps;
    endtask

    task automatic idleInputs;
        newGame = 1'b0;
        go      = 1'b0;
        hit     = 1'b0;
        steps   = 2'd0;
    endtask

    task automatic applyReset(input logic [1:0] code);
        idleInputs();
        n   = code;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Issue a hit, then count consecutive samples where p_da equals the expected one-hot.
    task automatic doMove(input logic [1:0] st, input logic [3:0] mask, output int pulses);
        go    = 1'b1;
        hit   = 1'b1;
        steps = st;
        tick();
        go     = 1'b0;
        hit    = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8 && pDa == mask; c++) begin
            pulses++;
            tick();
        end
        checkOutput("move.pda_dropped", int'(pDa), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int total;

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd0, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b1, 1'b1, 2'd3, 4'b0001, 2'd0, 1'b1, 5'd0, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[2]  = '{1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 5'd1, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[3]  = '{1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 5'd2, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd3, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd3, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[6]  = '{1'b0, 2'd2, 1'b1, 1'b1, 2'd2, 4'b0001, 2'd0, 1'b1, 5'd3, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1, 5'd4, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd5, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[9]  = '{1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 5'd5, 5'd6, 5'd12, 5'd18, 1'b0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd0, 5'd8, 5'd16, 5'd0, 1'b0};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 5'd0, 5'd8, 5'd16, 5'd0, 1'b0};
        vecs[12] = '{1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd2, 1'b0, 5'd0, 5'd8, 5'd16, 5'd0, 1'b0};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd0, 5'd8, 5'd16, 5'd0, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd0, 5'd8, 5'd16, 5'd0, 1'b0};
        vecs[15] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1, 5'd0, 5'd8, 5'd16, 5'd0, 1'b0};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 5'd1, 5'd8, 5'd16, 5'd0, 1'b0};

        // Reset state with four players, observed while reset is held.
        idleInputs();
        n   = 2'd2;
        rst = 1'b1;
        #3;
        checkOutput("rst.p_da", int'(pDa), 0);
        checkOutput("rst.busy", int'(busy), 0);
        checkOutput("rst.turn", int'(turn), 0);
        checkOutput("rst.winner_valid", int'(winnerValid), 0);
        checkOutput("rst.winner", int'(winner), 0);
        checkOutput("rst.pos3", int'(pos3), 18);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d.p_da", i), int'(pDa), int'(vecs[i].pda));
            checkOutput($sformatf("vec%0d.turn", i), int'(turn), int'(vecs[i].turn));
            checkOutput($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].busy));
            checkOutput($sformatf("vec%0d.pos0", i), int'(pos0), int'(vecs[i].p0));
            checkOutput($sformatf("vec%0d.pos1", i), int'(pos1), int'(vecs[i].p1));
            checkOutput($sformatf("vec%0d.pos2", i), int'(pos2), int'(vecs[i].p2));
            checkOutput($sformatf("vec%0d.pos3", i), int'(pos3), int'(vecs[i].p3));
            checkOutput($sformatf("vec%0d.winner_valid", i), int'(winnerValid), int'(vecs[i].wv));
        end
        idleInputs();

        // Player 1 of two walks across the 23 -> 0 wrap.
        applyReset(2'd0);
        checkOutput("wrap.pos1_start", int'(pos1), 12);
        go  = 1'b1;
        hit = 1'b0;
        tick();
        idleInputs();
        checkOutput("wrap.turn_to_1", int'(turn), 1);
        total = 0;
        for (int h = 0; h < 4; h++) begin
            doMove(2'd3, 4'b0010, pulses);
            checkOutput($sformatf("wrap.hit%0d_pulses", h), pulses, 3);
            total += pulses;
        end
        checkOutput("wrap.total_pulses", total, 12);
        checkOutput("wrap.pos1_end", int'(pos1), 0);
        checkOutput("wrap.pos0", int'(pos0), 0);
        checkOutput("wrap.turn_kept", int'(turn), 1);

        // Player 0 reaches distance 23, then a 3-step hit ends after one tile.
        applyReset(2'd0);
        for (int h = 0; h < 7; h++) begin
            doMove(2'd3, 4'b0001, pulses);
        end
        doMove(2'd2, 4'b0001, pulses);
        checkOutput("win.pos0_pre", int'(pos0), 23);
        checkOutput("win.wv_pre", int'(winnerValid), 0);
        doMove(2'd3, 4'b0001, pulses);
        checkOutput("win.pulses", pulses, 1);
        checkOutput("win.winner_valid", int'(winnerValid), 1);
        checkOutput("win.winner", int'(winner), 0);
        checkOutput("win.busy", int'(busy), 0);
        checkOutput("win.pos0", int'(pos0), 0);
        go    = 1'b1;
        hit   = 1'b1;
        steps = 2'd3;
        tick();
        checkOutput("done.go_hit_p_da", int'(pDa), 0);
        checkOutput("done.go_hit_pos0", int'(pos0), 0);
        hit = 1'b0;
        tick();
        idleInputs();
        checkOutput("done.go_miss_turn", int'(turn), 0);
        checkOutput("done.still_valid", int'(winnerValid), 1);
        newGame = 1'b1;
        n       = 2'd0;
        tick();
        idleInputs();
        checkOutput("newgame.winner_valid", int'(winnerValid), 0);
        checkOutput("newgame.pos1", int'(pos1), 12);

        // Reset lands in the second cycle of a three-tile move.
        go    = 1'b1;
        hit   = 1'b1;
        steps = 2'd3;
        tick();
        idleInputs();
        checkOutput("abort.p_da_c1", int'(pDa), 1);
        tick();
        checkOutput("abort.pos0_c2", int'(pos0), 1);
        #1;
        n   = 2'd2;
        rst = 1'b1;
        #1;
        checkOutput("abort.p_da", int'(pDa), 0);
        checkOutput("abort.busy", int'(busy), 0);
        checkOutput("abort.turn", int'(turn), 0);
        checkOutput("abort.pos0", int'(pos0), 0);
        checkOutput("abort.pos1", int'(pos1), 6);
        checkOutput("abort.pos3", int'(pos3), 18);
        #2;
        rst = 1'b0;
        tick();
        checkOutput("abort.after_p_da", int'(pDa), 0);
        checkOutput("abort.after_pos2", int'(pos2), 12);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
